// File: rtl/neo_frame_sequencer.sv
// Frame sequencer in front of a NeoPixel strand controller: double-buffered frame store,
// load/send handshake, periodic refresh. Define NEO_SEQ_DIRTY_SKIP_EN to skip refreshes of unchanged frames.
module neo_frame_sequencer #(
    parameter int NUM_PIXELS     = 5,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_pixel,
    input  logic [1:0]  wr_color,
    input  logic [7:0]  wr_level,
    input  logic        frame_go,
    input  logic        auto_en,
    input  logic        ready_to_load,
    input  logic        ready_to_send,
    output logic        load_color,
    output logic        send_it,
    output logic [2:0]  pixel_index,
    output logic [1:0]  color_index,
    output logic [7:0]  color_level,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);
    localparam int TW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(REFRESH_CYCLES - 1);
    localparam logic [4:0] PTR_LAST = 5'(3 * NUM_PIXELS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_LO, S_WAIT_HI} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_back  [NUM_PIXELS][3];
    logic [7:0]    r_front [NUM_PIXELS][3];
    logic [4:0]    r_ptr;
    logic [TW-1:0] r_timer;
    logic          r_pending;
    logic          r_frame_done;
    logic [15:0]   r_frame_count;
    logic          w_wr_ok;
    logic          w_tick;
    logic          w_start;
    logic          w_load;
    logic          w_req;
    logic          w_finish;
    logic [2:0]    w_pix;
    logic [1:0]    w_col;

    assign w_wr_ok  = wr_en && (wr_color != 2'd3) && (int'(wr_pixel) < NUM_PIXELS);
    assign w_tick   = auto_en && (r_timer == T_LAST);
    assign w_start  = (r_state == S_IDLE) && r_pending && ready_to_load;
    assign w_load   = (r_state == S_LOAD) && ready_to_load;
    assign w_finish = (r_state == S_WAIT_HI) && ready_to_load && ready_to_send;
    assign w_pix    = 3'(r_ptr / 5'd3);
    assign w_col    = 2'(r_ptr % 5'd3);

`ifdef NEO_SEQ_DIRTY_SKIP_EN
    logic r_dirty;

    // Refresh ticks only matter when the host changed something since the last snapshot.
    assign w_req = frame_go || (w_tick && r_dirty);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dirty <= 1'b0;
        end else if (w_wr_ok) begin
            r_dirty <= 1'b1;
        end else if (w_start) begin
            r_dirty <= 1'b0;
        end
    end
`else
    assign w_req = frame_go || w_tick;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_timer       <= '0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    r_back[p][c]  <= '0;
                    r_front[p][c] <= '0;
                end
            end
        end else begin
            r_state <= w_next;
            if (w_wr_ok) begin
                r_back[wr_pixel][wr_color] <= wr_level;
            end
            // Snapshot reads the pre-edge back buffer, so a same-cycle write waits for the next frame.
            if (w_start) begin
                r_front <= r_back;
            end
            if (w_start) begin
                r_ptr <= '0;
            end else if (w_load) begin
                r_ptr <= r_ptr + 5'd1;
            end
            if (!auto_en || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_req) begin
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
            r_frame_done <= w_finish;
            if (w_finish) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        load_color  = 1'b0;
        send_it     = 1'b0;
        pixel_index = '0;
        color_index = '0;
        color_level = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                load_color  = ready_to_load;
                pixel_index = w_pix;
                color_index = w_col;
                color_level = r_front[w_pix][w_col];
                if (w_load && (r_ptr == PTR_LAST)) w_next = S_SEND;
            end
            S_SEND: begin
                send_it = ready_to_send;
                if (ready_to_send) w_next = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!ready_to_send) w_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (w_finish) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Directed bench for neo_frame_sequencer with a strand-controller model and a beat scoreboard.
module tb_neo_frame_sequencer;
    localparam int NP = 5;
    localparam int RC = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_pixel = '0;
    logic [1:0]  wr_color = '0;
    logic [7:0]  wr_level = '0;
    logic        frame_go = 1'b0;
    logic        auto_en = 1'b0;
    logic        ready_to_load;
    logic        ready_to_send;
    logic        load_color;
    logic        send_it;
    logic [2:0]  pixel_index;
    logic [1:0]  color_index;
    logic [7:0]  color_level;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    neo_frame_sequencer #(.NUM_PIXELS(NP), .REFRESH_CYCLES(RC)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_pixel(wr_pixel),
        .wr_color(wr_color), .wr_level(wr_level), .frame_go(frame_go), .auto_en(auto_en),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
        .load_color(load_color), .send_it(send_it), .pixel_index(pixel_index),
        .color_index(color_index), .color_level(color_level), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [12:0] exp_q[$];
    logic [7:0]  mb [NP][3];
    int n_beats = 0, n_sends = 0, n_done = 0, beat_in_frame = 0;
    int t_first = 0, t_send = 0, t_done = 0, t_ready = 0;
    int send_hold = 3;
    bit drop_en = 1'b0;
    int exp_fc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back({3'(p), 2'(c), mb[p][c]});
    endtask

    task automatic do_write(input int px, input int c, input logic [7:0] lv);
        @(posedge clock); #1;
        wr_en = 1'b1; wr_pixel = 3'(px); wr_color = 2'(c); wr_level = lv;
        @(posedge clock); #1;
        wr_en = 1'b0;
        if (c != 3 && px < NP) mb[px][c] = lv;
    endtask

    task automatic pulse_go();
        @(posedge clock); #1; frame_go = 1'b1;
        @(posedge clock); #1; frame_go = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (n_done < target && i < budget) begin
            @(posedge clock); #2;
            i++;
        end
        chk("frame_done_wait", 32'(n_done >= target), 32'd1);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Strand controller model: optional ready_to_load stalls, busy period after send_it.
    initial begin
        bit saw_l, saw_s, saw_r;
        int s_beats = 0, hold = 0, drop = 0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        forever begin
            @(negedge clock);
            saw_l = load_color; saw_s = send_it; saw_r = reset;
            @(posedge clock); #1;
            if (saw_r) s_beats = 0;
            if (saw_l) s_beats++;
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin
                    ready_to_load = 1'b1; ready_to_send = 1'b1; t_ready = cyc;
                end
            end else if (drop > 0) begin
                drop--;
                if (drop == 0) ready_to_load = 1'b1;
            end
            if (saw_s) begin
                ready_to_load = 1'b0; ready_to_send = 1'b0; hold = send_hold; s_beats = 0;
            end else if (drop_en && saw_l && (s_beats == 3 || s_beats == 7)) begin
                ready_to_load = 1'b0; drop = 2;
            end
        end
    end

    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clock);
            if (reset) beat_in_frame = 0;
            if (load_color === 1'b1) begin
                if (beat_in_frame == 0) t_first = cyc;
                beat_in_frame++;
                n_beats++;
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({pixel_index, color_index, color_level}), 32'(e));
                end
            end
            if (send_it === 1'b1) begin
                n_sends++; t_send = cyc; beat_in_frame = 0;
            end
            if (frame_done === 1'b1) begin
                n_done++; t_done = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, s0, t_go, cnt, nf;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                mb[p][c] = 8'h00;

        repeat (3) @(posedge clock); #1;
        chk("rst_load_color", 32'(load_color), 32'd0);
        chk("rst_send_it", 32'(send_it), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_pixel_index", 32'(pixel_index), 32'd0);
        chk("rst_color_level", 32'(color_level), 32'd0);
        reset = 1'b0;

        // Frame 1: basic content, invalid writes, latency.
        do_write(4, 0, 8'hFF);
        do_write(1, 1, 8'hA0);
        do_write(2, 2, 8'hB3);
        do_write(1, 3, 8'hD4);
        do_write(5, 0, 8'h77);
        push_frame(); exp_fc++;
        b0 = n_beats;
        @(posedge clock); #1; t_go = cyc; frame_go = 1'b1;
        @(posedge clock); #1; frame_go = 1'b0;
        wait_done(1, 200);
        chk("f1_beats", 32'(n_beats - b0), 32'd15);
        chk("f1_sends", 32'(n_sends), 32'd1);
        chk("f1_first_lat", 32'(t_first), 32'(t_go + 2));
        chk("f1_send_lat", 32'(t_send), 32'(t_go + 17));
        chk("f1_count", 32'(frame_count), 32'(exp_fc));
        chk("f1_busy", 32'(busy), 32'd0);
        chk("f1_queue", 32'(exp_q.size()), 32'd0);
        chk("idle_pixel_index", 32'(pixel_index), 32'd0);
        chk("idle_color_level", 32'(color_level), 32'd0);

        // Frame 2: load stalls at beats 3 and 7, long strand busy period.
        drop_en = 1'b1; send_hold = 50;
        push_frame(); exp_fc++;
        b0 = n_beats;
        pulse_go();
        wait_done(2, 300);
        chk("f2_beats", 32'(n_beats - b0), 32'd15);
        chk("f2_sends", 32'(n_sends), 32'd2);
        chk("f2_stall_span", 32'(t_send), 32'(t_first + 19));
        chk("f2_done_timing", 32'(t_done), 32'(t_ready + 1));
        chk("f2_count", 32'(frame_count), 32'(exp_fc));
        chk("f2_busy", 32'(busy), 32'd0);
        drop_en = 1'b0; send_hold = 3;

        // Two go pulses while loading merge into one extra frame; mid-frame write shows only in it.
        push_frame(); exp_fc += 2;
        b0 = n_beats; d0 = n_done;
        pulse_go();
        for (int i = 0; i < 20 && n_beats == b0; i++) begin @(posedge clock); #2; end
        chk("f3_busy_in_load", 32'(busy), 32'd1);
        pulse_go();
        pulse_go();
        do_write(0, 0, 8'h55);
        push_frame();
        wait_done(d0 + 2, 300);
        repeat (60) @(posedge clock);
        #2;
        chk("f3_done_count", 32'(n_done - d0), 32'd2);
        chk("f3_beats", 32'(n_beats - b0), 32'd30);
        chk("f3_count", 32'(frame_count), 32'(exp_fc));
        chk("f3_queue", 32'(exp_q.size()), 32'd0);

        // Periodic refresh.
        do_write(3, 2, 8'h3C);
`ifdef NEO_SEQ_DIRTY_SKIP_EN
        nf = 1;
`else
        nf = 5;
`endif
        for (int i = 0; i < nf; i++) push_frame();
        exp_fc += nf;
        d0 = n_done;
        @(posedge clock); #1; auto_en = 1'b1;
        repeat (1050) @(posedge clock);
        #1; auto_en = 1'b0;
        repeat (100) @(posedge clock);
        #2;
        chk("auto_frames", 32'(n_done - d0), 32'(nf));
        chk("auto_count", 32'(frame_count), 32'(exp_fc));
        chk("auto_queue", 32'(exp_q.size()), 32'd0);

        // Reset during the 7th load beat abandons the frame.
        push_frame();
        s0 = n_sends;
        pulse_go();
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 7; i++) begin
            @(negedge clock);
            if (load_color === 1'b1) cnt++;
        end
        chk("rst7_reached", 32'(cnt), 32'd7);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst7_load_color", 32'(load_color), 32'd0);
        chk("rst7_send_it", 32'(send_it), 32'd0);
        chk("rst7_busy", 32'(busy), 32'd0);
        chk("rst7_count", 32'(frame_count), 32'd0);
        chk("rst7_color_level", 32'(color_level), 32'd0);
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #2;
        chk("rst7_no_send", 32'(n_sends), 32'(s0));
        chk("rst7_left_beats", 32'(exp_q.size()), 32'd8);
        chk("rst7_count_after", 32'(frame_count), 32'd0);
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/neo_frame_sequencer.md
Name: neo_frame_sequencer

Overview:
- Frame-level sequencer that sits in front of NeoPixelStrandController and owns its load/send handshake.
- Host writes per-pixel colour bytes into a double-buffered frame store at any time.
- On a manual go or a periodic refresh tick, the block snapshots the store and issues 3×NUM_PIXELS load_color beats, then send_it.
- It then waits for the strand to finish and reports completion.

Parameters:
- NUM_PIXELS, 5, number of LEDs on strand; pixel_index width fixed at 3, so 1..8.
- REFRESH_CYCLES, 100000, clock cycles between automatic refresh requests; must be ≥2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe to back buffer
- wr_pixel  in  3  pixel to write
- wr_color  in  2  0=red, 1=blue, 2=green, 3=invalid (write ignored)
- wr_level  in  8  colour intensity
- frame_go  in  1  request one frame send (pulse)
- auto_en  in  1  enable periodic refresh
- ready_to_load  in  1  from strand controller
- ready_to_send  in  1  from strand controller
- load_color  out  1  to strand controller
- send_it  out  1  to strand controller
- pixel_index  out  3  to strand controller
- color_index  out  2  to strand controller
- color_level  out  8  to strand controller
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- frame_count  out  16  frames completed, wraps 0xFFFF→0

Behaviour:
- Reset (synchronous, priority over everything):
  - State → IDLE; both buffers, ptr, timer, pending and frame_count → 0.
  - All outputs → 0 on the cycle after reset is sampled.
  - Reset mid-frame abandons the frame with no further beats.
- Back buffer writes:
  - Applied at the clock edge when wr_en is high.
  - Ignored if wr_color==3 or wr_pixel≥NUM_PIXELS.
  - Writes are accepted in every state.
- Pending flag:
  - Set by frame_go=1.
  - Set by the timer when auto_en=1 and the timer reaches REFRESH_CYCLES-1; the timer then wraps to 0.
  - auto_en=0 holds the timer at 0 but does not clear pending.
  - Requests arriving while busy merge into one queued frame.
- IDLE: when pending=1 and ready_to_load=1:
  - Copy back → front buffer.
  - Clear pending; ptr=0; go to LOAD.
  - A wr_en in the same cycle lands in the back buffer only, not in this frame.
  - A new set and a clear of pending in the same cycle: set wins.
- LOAD: ptr steps 0..3·NUM_PIXELS-1 in pixel-major order.
  - pixel = ptr/3; colour order 0 (R), 1 (B), 2 (G).
  - pixel_index, color_index and color_level are combinational from ptr and the front buffer, and are 0 outside LOAD.
  - load_color = (state==LOAD) & ready_to_load.
  - ptr advances only on cycles where load_color=1; when ready_to_load=0, hold ptr.
  - Last beat accepted → SEND.
- SEND: send_it = (state==SEND) & ready_to_send, for exactly one cycle, then → WAIT_LO.
- WAIT_LO: wait for ready_to_send=0 (strand has started transmitting) → WAIT_HI.
- WAIT_HI: wait for ready_to_load=1 and ready_to_send=1. Then:
  - Pulse frame_done for one cycle.
  - frame_count+1.
  - Go to IDLE; the next frame may start on the following cycle.
- Latency: frame_go at cycle t with the strand ready gives the first load_color at t+2 and send_it at t+2+3·NUM_PIXELS.

Optional Feature:
- Macro: NEO_SEQ_DIRTY_SKIP_EN.
- Defined:
  - A dirty bit is set by any accepted back-buffer write and cleared at the back→front copy.
  - A write in the copy cycle leaves dirty set.
  - Timer ticks set pending only when dirty=1.
  - frame_go always sets pending.
- Undefined: the dirty bit does not exist, and every timer tick sets pending.

Test Plan:
- Reset then write (px4, R, FF), (px1, B, A0), (px2, G, B3), (px1, color 3, D4); pulse frame_go -> 15 load_color beats in order px0R..px4G. Beat 3·1+1 carries A0, beat 3·2+2 carries B3, beat 12 carries FF; D4 never appears. Then one send_it pulse.
- Strand model drops ready_to_load on beats 3 and 7 for 2 cycles -> ptr holds, no beat skipped or duplicated, still exactly 15 beats.
- After send_it, strand holds ready_to_send=0 for 50 cycles -> frame_done pulses one cycle after both readies return high; frame_count=1; busy is low afterwards.
- frame_go pulsed twice during LOAD -> exactly one extra frame follows, frame_count=2. A wr_en to px0 R=0x55 during the first frame shows 0x55 only in the second frame.
- auto_en=1 with REFRESH_CYCLES=200, no writes, over 1000 cycles -> 5 frames without NEO_SEQ_DIRTY_SKIP_EN. With the macro defined: 1 frame after a single write, then none.
- Assert reset in the 7th LOAD beat -> load_color, send_it and busy are 0 the next cycle; frame_count=0; no send_it ever issued for that frame.
